fpga_reset_requester: RTL and testbench
=======================================

// Module: fpga_reset_requester
// PURPOSE
//  Initiator side of the board reset chain: gathers reset requests (MMCM lock loss, push-button,
//  watchdog, software), drives the asynchronous areset_out into the reset hold/sync chain, holds it
//  a minimum time, then waits for the chain's last-domain reset to release before accepting new
//  requests. Records a sticky cause vector for software. Runs on the free-running board clock.
// PARAMETERS
//  SYNC_STAGES    4    flops in every async-input synchronizer
//  DEBOUNCE_BITS  8    button must be stable 2^DEBOUNCE_BITS cycles to change state
//  ASSERT_CYCLES  64   minimum areset_out high time, counted only while locked
//  COOLDOWN_CYCLES 16  cycles after release during which requests are ignored (not lost: lock loss excepted)
//  TIMEOUT_BITS   16   WAIT_DONE abandoned after 2^TIMEOUT_BITS cycles
// PORTS
//  clock          in   1  free-running board oscillator
//  areset         in   1  asynchronous, active-high; power-on / board reset
//  mmcm_locked    in   1  async; PLL/MMCM lock, synchronized internally
//  btn_n          in   1  async; push-button, active-low, synchronized + debounced
//  wdt_req        in   1  single-cycle pulse, clock domain; watchdog expiry
//  sw_req         in   1  single-cycle pulse, clock domain; software reset request
//  chain_reset    in   1  async; reset output of the last domain in the chain, synchronized
//  cause_clear    in   1  single-cycle pulse; clears cause vector
//  areset_out     out  1  reset request to chain; registered, glitch-free
//  busy           out  1  high in every state except IDLE
//  cause          out  6  sticky: [0]POR [1]LOCK_LOSS [2]BUTTON [3]WDT [4]SW [5]TIMEOUT
// BEHAVIOUR
//  Reset (areset high): state=HOLD, counters=0, areset_out=1, busy=1, cause=6'b000001, sync flops=1,
//   debounced button=released.
//  States (encoding in package):
//   HOLD: areset_out=1. cnt increments while lock_s=1; lock_s=0 clears cnt. cnt==ASSERT_CYCLES-1 with
//    lock_s=1 -> WAIT_DONE, cnt=0. Minimum HOLD = ASSERT_CYCLES cycles after lock_s rises.
//   WAIT_DONE: areset_out=0. chain_s==0 -> COOLDOWN. lock_s==0 -> HOLD, set LOCK_LOSS.
//    tmo==2^TIMEOUT_BITS-1 -> HOLD, set TIMEOUT.
//   COOLDOWN: areset_out=0, COOLDOWN_CYCLES cycles then IDLE. wdt/sw/button requests arriving here
//    are latched in a 1-bit pending flag and serviced on IDLE entry. lock_s==0 -> HOLD at once.
//   IDLE: busy=0. Any of {lock_s==0, button press, wdt_req, sw_req, pending} -> HOLD next cycle,
//    areset_out rises on that same transition edge (1 cycle request-to-assert latency).
//  Requests during HOLD/WAIT_DONE: set cause bit only, no restart (except lock loss as above).
//  Button: press = debounced level going released->pressed; one request per press; held button does
//   not re-trigger.
//  Cause: OR of all events since last clear; simultaneous events set all their bits. cause_clear
//   with a same-cycle event: cleared except the new event bit (set wins). POR bit only set by areset.
//  areset_out from a flop, never combinational; deasserts only on clock edge.
//  areset mid-operation: immediate return to HOLD, all above reset values.
//  Widths: cnt $clog2(ASSERT_CYCLES) bits min 1, cooldown counter $clog2(COOLDOWN_CYCLES+1), tmo
//   TIMEOUT_BITS; all saturate/clear, never wrap in-state.
// STRUCTURE
//  Package fpga_reset_pkg: state enum {HOLD,WAIT_DONE,COOLDOWN,IDLE}, CAUSE_* bit index localparams,
//   CAUSE_W=6.
//  Sub-module fpga_reset_in_sync: SYNC_STAGES-flop synchronizer, async preset by areset, used for
//   mmcm_locked (preset 0 semantics via inversion), btn_n and chain_reset (preset 1).
//  Top: debouncer, FSM, counters, cause register.
// TESTING
//  1 Power-on: areset 10 cycles, mmcm_locked=1 from cycle 0, chain_reset falls 5 cycles after
//    areset_out -> areset_out high 64+SYNC_STAGES cycles, busy falls 16 later, cause=6'h01.
//  2 Lock loss in IDLE: mmcm_locked=0 for 3 cycles -> areset_out=1 SYNC_STAGES+1 cycles later,
//    HOLD counter restarts on relock, cause |= 6'h02.
//  3 Button bounce: btn_n toggling every 10 cycles for 200 cycles -> no request; held low 300 cycles
//    -> exactly one reset, cause |= 6'h04.
//  4 sw_req during COOLDOWN -> second reset starts on first IDLE cycle; wdt_req during HOLD -> no
//    restart, cause |= 6'h08.
//  5 chain_reset stuck 1 (TIMEOUT_BITS=6) -> return to HOLD after 64 WAIT_DONE cycles, cause bit5 set.
//  6 cause_clear same cycle as sw_req -> cause==6'h10 next cycle.

Source files
------------

// File: rtl/fpga_reset_pkg.sv
// Shared types for the board reset requester: FSM state encoding and cause-vector layout.
package fpga_reset_pkg;

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        WAIT_DONE = 2'd1,
        COOLDOWN  = 2'd2,
        IDLE      = 2'd3
    } reset_state_t;

    localparam int CAUSE_W         = 6;
    localparam int CAUSE_POR       = 0;
    localparam int CAUSE_LOCK_LOSS = 1;
    localparam int CAUSE_BUTTON    = 2;
    localparam int CAUSE_WDT       = 3;
    localparam int CAUSE_SW        = 4;
    localparam int CAUSE_TIMEOUT   = 5;

    typedef logic [CAUSE_W-1:0] cause_t;

    function automatic cause_t cause_mask(input int unsigned idx);
        cause_mask = cause_t'(1) << idx;
    endfunction

endpackage

// File: rtl/fpga_reset_requester_if.sv
// Request/status bundle between the reset requester and the board: request sources in, reset and cause out.
interface fpga_reset_requester_if;
    import fpga_reset_pkg::*;

    logic   mmcm_locked;
    logic   btn_n;
    logic   wdt_req;
    logic   sw_req;
    logic   chain_reset;
    logic   cause_clear;
    logic   areset_out;
    logic   busy;
    cause_t cause;

    modport master (
        input  mmcm_locked, btn_n, wdt_req, sw_req, chain_reset, cause_clear,
        output areset_out, busy, cause
    );

    modport slave (
        output mmcm_locked, btn_n, wdt_req, sw_req, chain_reset, cause_clear,
        input  areset_out, busy, cause
    );

endinterface

// File: rtl/fpga_reset_in_sync.sv
// Multi-flop synchronizer for asynchronous inputs; every stage presets to 1 while areset is high.
module fpga_reset_in_sync #(
    parameter int STAGES = 4
) (
    input  logic clock,
    input  logic areset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage;

    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            stage <= '1;
        end else begin
            stage <= {stage[STAGES-2:0], d};
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/fpga_reset_requester.sv
// Reset-chain initiator: collects reset requests, holds areset_out a minimum locked time,
// waits for the chain to release, then cools down before accepting new requests.
module fpga_reset_requester
    import fpga_reset_pkg::*;
#(
    parameter int SYNC_STAGES     = 4,
    parameter int DEBOUNCE_BITS   = 8,
    parameter int ASSERT_CYCLES   = 64,
    parameter int COOLDOWN_CYCLES = 16,
    parameter int TIMEOUT_BITS    = 16
) (
    input  logic                    clock,
    input  logic                    areset,
    fpga_reset_requester_if.master  req
);

    localparam int CNT_W = (ASSERT_CYCLES > 1) ? $clog2(ASSERT_CYCLES) : 1;
    localparam int CD_W  = $clog2(COOLDOWN_CYCLES + 1);

    logic lock_n_s;
    logic lock_s;
    logic btn_s;
    logic chain_s;

    // Lock is inverted around the synchronizer so it reads as "not locked" while in reset.
    fpga_reset_in_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clock  (clock),
        .areset (areset),
        .d      (~req.mmcm_locked),
        .q      (lock_n_s)
    );

    fpga_reset_in_sync #(.STAGES(SYNC_STAGES)) u_btn_sync (
        .clock  (clock),
        .areset (areset),
        .d      (req.btn_n),
        .q      (btn_s)
    );

    fpga_reset_in_sync #(.STAGES(SYNC_STAGES)) u_chain_sync (
        .clock  (clock),
        .areset (areset),
        .d      (req.chain_reset),
        .q      (chain_s)
    );

    assign lock_s = ~lock_n_s;

    logic                     btn_db;
    logic [DEBOUNCE_BITS-1:0] db_cnt;
    logic                     db_flip;
    logic                     btn_press;

    assign db_flip   = (btn_s != btn_db) && (db_cnt == '1);
    assign btn_press = db_flip && btn_db;

    // btn_db is the debounced level (1 = released); it only follows btn_s after an unbroken run of disagreement.
    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            btn_db <= 1'b1;
            db_cnt <= '0;
        end else if (btn_s == btn_db) begin
            db_cnt <= '0;
        end else if (db_flip) begin
            btn_db <= btn_s;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DEBOUNCE_BITS'(1);
        end
    end

    reset_state_t            state;
    reset_state_t            state_nxt;
    logic [CNT_W-1:0]        hold_cnt;
    logic [CD_W-1:0]         cd_cnt;
    logic [TIMEOUT_BITS-1:0] tmo;
    logic                    pending;
    logic                    areset_out_r;
    logic                    busy;
    cause_t                  cause_r;
    cause_t                  events;

    logic hold_done;
    logic cd_done;
    logic wait_timeout;
    logic timeout_evt;
    logic lock_lost;
    logic user_req;

    assign hold_done    = lock_s && (hold_cnt == CNT_W'(ASSERT_CYCLES - 1));
    assign cd_done      = (cd_cnt == CD_W'(COOLDOWN_CYCLES - 1));
    assign wait_timeout = (tmo == '1);
    assign timeout_evt  = (state == WAIT_DONE) && lock_s && chain_s && wait_timeout;
    assign lock_lost    = !lock_s && (state != HOLD);
    assign user_req     = btn_press || req.wdt_req || req.sw_req;

    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            state <= HOLD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HOLD: begin
                if (hold_done) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!lock_s)           state_nxt = HOLD;
                else if (!chain_s)     state_nxt = COOLDOWN;
                else if (wait_timeout) state_nxt = HOLD;
            end
            COOLDOWN: begin
                if (!lock_s)      state_nxt = HOLD;
                else if (cd_done) state_nxt = IDLE;
            end
            IDLE: begin
                if (!lock_s || user_req || pending) state_nxt = HOLD;
            end
            default: state_nxt = HOLD;
        endcase
    end

    always_comb begin
        busy                    = (state != IDLE);
        events                  = '0;
        events[CAUSE_LOCK_LOSS] = lock_lost;
        events[CAUSE_BUTTON]    = btn_press;
        events[CAUSE_WDT]       = req.wdt_req;
        events[CAUSE_SW]        = req.sw_req;
        events[CAUSE_TIMEOUT]   = timeout_evt;
    end

    // Registered from the next state so areset_out rises on the same edge that enters HOLD.
    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            areset_out_r <= 1'b1;
        end else begin
            areset_out_r <= (state_nxt == HOLD);
        end
    end

    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            hold_cnt <= '0;
            cd_cnt   <= '0;
            tmo      <= '0;
        end else begin
            if (state != HOLD || !lock_s || hold_done) hold_cnt <= '0;
            else                                       hold_cnt <= hold_cnt + CNT_W'(1);

            if (state != COOLDOWN || cd_done) cd_cnt <= '0;
            else                              cd_cnt <= cd_cnt + CD_W'(1);

            if (state != WAIT_DONE || wait_timeout) tmo <= '0;
            else                                    tmo <= tmo + TIMEOUT_BITS'(1);
        end
    end

    // Requests arriving in COOLDOWN are remembered and replayed once IDLE is reached.
    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            pending <= 1'b0;
        end else if (state_nxt == HOLD) begin
            pending <= 1'b0;
        end else if (state == COOLDOWN && user_req) begin
            pending <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            cause_r <= cause_mask(CAUSE_POR);
        end else begin
            cause_r <= (req.cause_clear ? '0 : cause_r) | events;
        end
    end

    assign req.areset_out = areset_out_r;
    assign req.busy       = busy;
    assign req.cause      = cause_r;

endmodule

// File: tb/tb_fpga_reset_requester.sv
// Self-checking bench for fpga_reset_requester: a vector table plus hand-written corner sequences,
// with expected reset events queued at stimulus time and checked when areset_out rises and falls.
module tb_fpga_reset_requester;
    import fpga_reset_pkg::*;

    localparam int SYNC_STAGES     = 4;
    localparam int DEBOUNCE_BITS   = 8;
    localparam int ASSERT_CYCLES   = 64;
    localparam int COOLDOWN_CYCLES = 16;
    localparam int TIMEOUT_BITS    = 6;
    localparam int CHAIN_DELAY     = 5;
    localparam int POR_HIGH        = ASSERT_CYCLES + SYNC_STAGES;
    localparam int RELEASE_TO_IDLE = (CHAIN_DELAY - 1) + SYNC_STAGES + 1 + COOLDOWN_CYCLES;
    localparam int BTN_LATENCY     = SYNC_STAGES + (1 << DEBOUNCE_BITS);
    localparam int WAIT_LIMIT      = 1 << TIMEOUT_BITS;

    typedef enum int {STIM_SW, STIM_WDT, STIM_LOCK, STIM_BTN} stim_t;
    typedef struct {
        stim_t      kind;
        int         lat;
        int         high;
        logic [5:0] exp_cause;
    } vec_t;
    typedef struct {
        int lat;
        int high;
    } exp_t;

    logic clock = 1'b0;
    logic areset;

    fpga_reset_requester_if rif();

    fpga_reset_requester #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_BITS   (DEBOUNCE_BITS),
        .ASSERT_CYCLES   (ASSERT_CYCLES),
        .COOLDOWN_CYCLES (COOLDOWN_CYCLES),
        .TIMEOUT_BITS    (TIMEOUT_BITS)
    ) dut (
        .clock  (clock),
        .areset (areset),
        .req    (rif.master)
    );

    int   cycle = 0;
    int   stamp = 0;
    int   assertions = 0;
    int   failures = 0;
    exp_t sb_q[$];
    exp_t cur;
    bit   cur_valid = 1'b0;
    logic prev_ao = 1'b1;
    int   t_rise = 0;
    bit   chain_stuck = 1'b0;
    int   chain_cnt = 0;
    vec_t vecs[4];

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertions++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic failTimeout(input string name);
        assertions++;
        failures++;
        $display("[TB] FAIL %s: wait bound expired at cycle %0d", name, cycle);
    endtask

    task automatic pushExpect(input int lat, input int high);
        exp_t e;
        e.lat  = lat;
        e.high = high;
        sb_q.push_back(e);
    endtask

    task automatic waitAresetOut(input logic level, input int budget, input string name);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (rif.areset_out !== level && n < budget);
        if (rif.areset_out !== level) failTimeout(name);
    endtask

    task automatic waitBusy(input logic level, input int budget, input string name);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (rif.busy !== level && n < budget);
        if (rif.busy !== level) failTimeout(name);
    endtask

    task automatic applyStimulus(input stim_t kind);
        @(negedge clock);
        stamp = cycle;
        case (kind)
            STIM_SW: begin
                rif.sw_req = 1'b1;
                @(negedge clock);
                rif.sw_req = 1'b0;
            end
            STIM_WDT: begin
                rif.wdt_req = 1'b1;
                @(negedge clock);
                rif.wdt_req = 1'b0;
            end
            STIM_LOCK: begin
                rif.mmcm_locked = 1'b0;
                repeat (3) @(negedge clock);
                rif.mmcm_locked = 1'b1;
            end
            STIM_BTN: begin
                rif.btn_n = 1'b0;
                repeat (300) @(negedge clock);
                rif.btn_n = 1'b1;
            end
            default: ;
        endcase
    endtask

    task automatic clearCause();
        @(negedge clock);
        rif.cause_clear = 1'b1;
        @(negedge clock);
        rif.cause_clear = 1'b0;
        checkOutput("cause_clear", rif.cause, 0);
    endtask

    // Downstream chain: follows areset_out high at once, releases CHAIN_DELAY cycles after it drops.
    always @(negedge clock) begin
        if (rif.areset_out) begin
            rif.chain_reset = 1'b1;
            chain_cnt = 0;
        end else if (!chain_stuck) begin
            if (chain_cnt < CHAIN_DELAY) chain_cnt++;
            if (chain_cnt >= CHAIN_DELAY) rif.chain_reset = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (!areset) begin
            if (rif.areset_out && !prev_ao) begin
                t_rise = cycle;
                if (sb_q.size() == 0) begin
                    assertions++;
                    failures++;
                    cur_valid = 1'b0;
                    $display("[TB] FAIL unexpected_reset: areset_out rose at cycle %0d, none expected", cycle);
                end else begin
                    cur = sb_q.pop_front();
                    cur_valid = 1'b1;
                    if (cur.lat >= 0) checkOutput("req_to_assert_latency", cycle - stamp, cur.lat);
                end
            end
            if (!rif.areset_out && prev_ao && cur_valid) begin
                if (cur.high >= 0) checkOutput("assert_duration", cycle - t_rise, cur.high);
                cur_valid = 1'b0;
            end
        end
        prev_ao = rif.areset_out;
    end

    initial begin
        #(100000 * 10);
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        int  t0;
        logic busy_seen;

        areset          = 1'b1;
        rif.mmcm_locked = 1'b1;
        rif.btn_n       = 1'b1;
        rif.wdt_req     = 1'b0;
        rif.sw_req      = 1'b0;
        rif.cause_clear = 1'b0;

        vecs[0] = '{STIM_SW,   1,           ASSERT_CYCLES,     6'h10};
        vecs[1] = '{STIM_WDT,  1,           ASSERT_CYCLES,     6'h08};
        vecs[2] = '{STIM_LOCK, SYNC_STAGES + 1, ASSERT_CYCLES + 2, 6'h02};
        vecs[3] = '{STIM_BTN,  BTN_LATENCY, ASSERT_CYCLES,     6'h04};

        // Power-on
        repeat (10) @(negedge clock);
        checkOutput("reset_areset_out", rif.areset_out, 1);
        checkOutput("reset_busy", rif.busy, 1);
        checkOutput("reset_cause", rif.cause, 6'h01);
        areset = 1'b0;
        t0 = cycle;
        waitAresetOut(1'b0, 500, "por_release");
        checkOutput("por_assert_cycles", cycle - t0, POR_HIGH);
        t0 = cycle;
        waitBusy(1'b0, 500, "por_idle");
        checkOutput("por_release_to_idle", cycle - t0, RELEASE_TO_IDLE);
        checkOutput("por_cause", rif.cause, 6'h01);

        // Bouncing button never settles long enough to count as a press
        busy_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rif.btn_n = ~rif.btn_n;
            repeat (10) begin
                @(negedge clock);
                busy_seen = busy_seen | rif.busy;
            end
        end
        repeat (300) begin
            @(negedge clock);
            busy_seen = busy_seen | rif.busy;
        end
        checkOutput("bounce_no_request", busy_seen, 0);

        foreach (vecs[i]) begin
            clearCause();
            pushExpect(vecs[i].lat, vecs[i].high);
            applyStimulus(vecs[i].kind);
            waitAresetOut(1'b1, 400, $sformatf("vec%0d_assert", i));
            waitBusy(1'b0, 2000, $sformatf("vec%0d_idle", i));
            checkOutput($sformatf("vec%0d_cause", i), rif.cause, vecs[i].exp_cause);
            checkOutput($sformatf("vec%0d_sb_drain", i), sb_q.size(), 0);
        end

        // Held button and its release must not produce a second reset
        busy_seen = 1'b0;
        repeat (400) begin
            @(negedge clock);
            busy_seen = busy_seen | rif.busy;
        end
        checkOutput("btn_single_reset", busy_seen, 0);

        // Request in COOLDOWN restarts on the first IDLE cycle; watchdog in HOLD only records cause
        clearCause();
        pushExpect(1, ASSERT_CYCLES);
        applyStimulus(STIM_SW);
        waitAresetOut(1'b0, 200, "t4_first_release");
        repeat (13) @(negedge clock);
        pushExpect(-1, ASSERT_CYCLES);
        applyStimulus(STIM_SW);
        waitBusy(1'b0, 200, "t4_idle");
        @(negedge clock);
        checkOutput("pending_restart", rif.areset_out, 1);
        repeat (10) @(negedge clock);
        applyStimulus(STIM_WDT);
        waitBusy(1'b0, 500, "t4_done");
        checkOutput("t4_cause", rif.cause, 6'h18);
        checkOutput("t4_sb_drain", sb_q.size(), 0);

        // Stuck chain: WAIT_DONE gives up after 2^TIMEOUT_BITS cycles
        clearCause();
        chain_stuck = 1'b1;
        pushExpect(1, ASSERT_CYCLES);
        pushExpect(-1, ASSERT_CYCLES);
        applyStimulus(STIM_SW);
        waitAresetOut(1'b0, 200, "t5_release");
        t0 = cycle;
        waitAresetOut(1'b1, 200, "t5_timeout");
        checkOutput("timeout_gap", cycle - t0, WAIT_LIMIT);
        checkOutput("timeout_cause", rif.cause, 6'h30);
        chain_stuck = 1'b0;
        waitBusy(1'b0, 500, "t5_idle");
        checkOutput("t5_cause", rif.cause, 6'h30);
        checkOutput("t5_sb_drain", sb_q.size(), 0);

        // Clear and new event on the same cycle: the new bit survives
        @(negedge clock);
        pushExpect(1, ASSERT_CYCLES);
        stamp = cycle;
        rif.cause_clear = 1'b1;
        rif.sw_req = 1'b1;
        @(negedge clock);
        rif.cause_clear = 1'b0;
        rif.sw_req = 1'b0;
        checkOutput("clear_vs_set", rif.cause, 6'h10);
        waitBusy(1'b0, 500, "t6_idle");
        checkOutput("t6_cause", rif.cause, 6'h10);

        // Board reset mid-operation acts immediately
        @(negedge clock);
        #2 areset = 1'b1;
        #1;
        checkOutput("mid_areset_out", rif.areset_out, 1);
        checkOutput("mid_busy", rif.busy, 1);
        checkOutput("mid_cause", rif.cause, 6'h01);
        repeat (3) @(negedge clock);
        areset = 1'b0;
        t0 = cycle;
        waitAresetOut(1'b0, 500, "mid_release");
        checkOutput("mid_assert_cycles", cycle - t0, POR_HIGH);
        waitBusy(1'b0, 500, "mid_idle");
        checkOutput("mid_final_cause", rif.cause, 6'h01);
        checkOutput("final_sb_drain", sb_q.size(), 0);

        repeat (5) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
